// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register and a loadable instruction memory.
// A small FSM sequences program loading, normal fetch and halt on a dedicated opcode.
module fetch_unit #(
  parameter int unsigned PC_WIDTH = 6,
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                Taken,
  input  logic [PC_WIDTH-1:0] PCJin,
  input  logic                prog_en,
  input  logic                prog_we,
  input  logic [PC_WIDTH-1:0] prog_addr,
  input  logic [31:0]         prog_data,
  output logic [31:0]         Instruction,
  output logic [PC_WIDTH-1:0] PCnext,
  output logic                valid,
  output logic                halted,
  output logic [PC_WIDTH-1:0] pc
);

  localparam int unsigned Depth = 2 ** PC_WIDTH;
  localparam logic [PC_WIDTH-1:0] PcZero = '0;
  localparam logic [PC_WIDTH-1:0] PcOne  = PC_WIDTH'(1);

  typedef enum logic [1:0] {StRun, StLoad, StHalt} state_e;

  state_e              r_state, w_state_d;
  logic [PC_WIDTH-1:0] r_pc, w_pc_d;
  logic [PC_WIDTH-1:0] r_pcnext, w_pcnext_d;
  logic [31:0]         r_instr, w_instr_d;
  logic                r_valid, w_valid_d;

  logic [31:0]         r_mem [Depth];
  logic [31:0]         w_word;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_word   = r_mem[r_pc];
  assign w_pc_inc = r_pc + PcOne;

  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_pcnext_d = r_pcnext;
    w_instr_d  = r_instr;
    w_valid_d  = r_valid;
    unique case (r_state)
      StLoad: begin
        w_pc_d     = PcZero;
        w_instr_d  = NOP_WORD;
        w_pcnext_d = PcZero;
        w_valid_d  = 1'b0;
        if (!prog_en) begin
          w_state_d = StRun;
        end
      end
      StHalt: begin
        // Taken and stall are deliberately ignored; only loading leaves HALT.
        if (prog_en) begin
          w_state_d = StLoad;
          w_pc_d    = PcZero;
        end
      end
      default: begin
        if (prog_en) begin
          w_state_d  = StLoad;
          w_pc_d     = PcZero;
          w_instr_d  = NOP_WORD;
          w_pcnext_d = PcZero;
          w_valid_d  = 1'b0;
        end else if (Taken) begin
          // Flush the wrong-path word; redirect outranks stall.
          w_pc_d     = PCJin;
          w_instr_d  = NOP_WORD;
          w_pcnext_d = PcZero;
          w_valid_d  = 1'b0;
        end else if (stall) begin
          w_pc_d = r_pc;
        end else if (w_word[31:26] == HALT_OP) begin
          w_state_d  = StHalt;
          w_instr_d  = NOP_WORD;
          w_pcnext_d = PcZero;
          w_valid_d  = 1'b0;
        end else begin
          w_instr_d  = w_word;
          w_pcnext_d = w_pc_inc;
          w_valid_d  = 1'b1;
          w_pc_d     = w_pc_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StRun;
      r_pc     <= PcZero;
      r_pcnext <= PcZero;
      r_instr  <= NOP_WORD;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_pcnext <= w_pcnext_d;
      r_instr  <= w_instr_d;
      r_valid  <= w_valid_d;
    end
  end

  // Memory is intentionally outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (r_state == StLoad && prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  assign Instruction = r_instr;
  assign PCnext      = r_pcnext;
  assign valid       = r_valid;
  assign halted      = (r_state == StHalt);
  assign pc          = r_pc;

endmodule
